// File: rtl/sprite_pkg.sv
// sprite_pkg: shared widths, initial sprite positions and FSM/direction types for sprite_grid_mover
package sprite_pkg;
  localparam int COORD_W = 10;
  localparam int N_SPRITES = 4;
  localparam logic [N_SPRITES*COORD_W-1:0] INIT_X = {10'd320, 10'd510, 10'd400, 10'd95};
  localparam logic [N_SPRITES*COORD_W-1:0] INIT_Y = {10'd200, 10'd85, 10'd400, 10'd85};
  typedef enum logic [1:0] {DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} dir_t;
  typedef enum logic [1:0] {IDLE, PENDING, STEP} state_t;
  function automatic logic is_one_hot(input logic [N_SPRITES-1:0] s);
    return (s != '0) && ((s & (s - N_SPRITES'(1))) == '0);
  endfunction
endpackage

// File: rtl/btn_edge_detect.sv
// btn_edge_detect: registered rising-edge detectors on {right,left,down,up} with up>down>left>right priority
module btn_edge_detect
  import sprite_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] btn_i,
  output logic       valid_o,
  output dir_t       dir_o
);
  logic [3:0] btn_q, edge_q;
  always_ff @(posedge clk) begin
    if (!reset) begin
      btn_q  <= '0;
      edge_q <= '0;
    end else begin
      btn_q  <= btn_i;
      edge_q <= btn_i & ~btn_q;
    end
  end
  assign valid_o = |edge_q;
  assign dir_o   = edge_q[0] ? DIR_UP : edge_q[1] ? DIR_DOWN : edge_q[2] ? DIR_LEFT : DIR_RIGHT;
endmodule

// File: rtl/sprite_grid_mover.sv
// sprite_grid_mover: one grid-cell move per button press, applied on frame_tick; SPRITE_STEP_ANIM_EN slides 1 px per frame instead
module sprite_grid_mover
  import sprite_pkg::*;
#(
  parameter int GRID_STEP = 20,
  parameter int X_MIN     = 10,
  parameter int X_MAX     = 629,
  parameter int Y_MIN     = 10,
  parameter int Y_MAX     = 469
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           frame_tick,
  input  logic                           btn_up,
  input  logic                           btn_down,
  input  logic                           btn_left,
  input  logic                           btn_right,
  input  logic [N_SPRITES-1:0]           sel,
  output logic [N_SPRITES*COORD_W-1:0]   sprite_x,
  output logic [N_SPRITES*COORD_W-1:0]   sprite_y,
  output logic                           moving,
  output logic                           move_done,
  output logic                           move_reject
);
  typedef logic [COORD_W:0] ext_t;
  typedef logic [$clog2(N_SPRITES)-1:0] idx_t;
  logic               req_v;
  dir_t               req_dir;
  state_t             state_q;
  idx_t               idx_q, idx_d;
  dir_t               dir_q;
  logic [COORD_W-1:0] tgt_q, cur_d, coord_d;
  ext_t               tgt_d;
  logic [COORD_W-1:0] x_q [N_SPRITES];
  logic [COORD_W-1:0] y_q [N_SPRITES];
  logic               in_range, apply, done_q, rej_q;
  btn_edge_detect u_edge (
    .clk    (clk),
    .reset  (reset),
    .btn_i  ({btn_right, btn_left, btn_down, btn_up}),
    .valid_o(req_v),
    .dir_o  (req_dir)
  );
  // Target is formed one bit wider so a step below zero lands out of range instead of wrapping.
  always_comb begin
    idx_d    = sel[1] ? idx_t'(1) : sel[2] ? idx_t'(2) : sel[3] ? idx_t'(3) : idx_t'(0);
    cur_d    = (req_dir inside {DIR_UP, DIR_DOWN}) ? y_q[idx_d] : x_q[idx_d];
    tgt_d    = (req_dir inside {DIR_DOWN, DIR_RIGHT}) ? ext_t'(cur_d) + ext_t'(GRID_STEP)
                                                      : ext_t'(cur_d) - ext_t'(GRID_STEP);
    in_range = (req_dir inside {DIR_UP, DIR_DOWN})
             ? (tgt_d >= ext_t'(Y_MIN) && tgt_d <= ext_t'(Y_MAX))
             : (tgt_d >= ext_t'(X_MIN) && tgt_d <= ext_t'(X_MAX));
  end
`ifdef SPRITE_STEP_ANIM_EN
  logic [GRID_STEP-1:0] cnt_q;
  assign coord_d = ((dir_q inside {DIR_UP, DIR_DOWN}) ? y_q[idx_q] : x_q[idx_q])
                 + ((dir_q inside {DIR_DOWN, DIR_RIGHT}) ? COORD_W'(1) : {COORD_W{1'b1}});
  assign apply   = frame_tick && (state_q == PENDING || (state_q == STEP && !cnt_q[GRID_STEP-1]));
`else
  assign coord_d = tgt_q;
  assign apply   = frame_tick && state_q == PENDING;
`endif
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      dir_q   <= DIR_UP;
      tgt_q   <= '0;
      done_q  <= 1'b0;
      rej_q   <= 1'b0;
      for (int i = 0; i < N_SPRITES; i++) begin
        x_q[i] <= INIT_X[i*COORD_W +: COORD_W];
        y_q[i] <= INIT_Y[i*COORD_W +: COORD_W];
      end
`ifdef SPRITE_STEP_ANIM_EN
      cnt_q <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      rej_q  <= 1'b0;
      if (apply) begin
        if (dir_q inside {DIR_UP, DIR_DOWN}) y_q[idx_q] <= coord_d;
        else x_q[idx_q] <= coord_d;
      end
      case (state_q)
        IDLE: if (req_v && is_one_hot(sel)) begin
          if (in_range) begin
            state_q <= PENDING;
            idx_q   <= idx_d;
            dir_q   <= req_dir;
            tgt_q   <= tgt_d[COORD_W-1:0];
          end else rej_q <= 1'b1;
        end
        PENDING: if (frame_tick) begin
          state_q <= STEP;
`ifdef SPRITE_STEP_ANIM_EN
          cnt_q <= GRID_STEP'(1);
`endif
        end
`ifdef SPRITE_STEP_ANIM_EN
        // Thermometer count: bit k set once k+1 pixels have been applied.
        STEP: if (cnt_q[GRID_STEP-1]) begin
          state_q <= IDLE;
          done_q  <= 1'b1;
        end else if (frame_tick) cnt_q <= {cnt_q[GRID_STEP-2:0], 1'b1};
`else
        STEP: begin
          state_q <= IDLE;
          done_q  <= 1'b1;
        end
`endif
        default: state_q <= IDLE;
      endcase
    end
  end
  for (genvar i = 0; i < N_SPRITES; i++) begin : g_pack
    assign sprite_x[i*COORD_W +: COORD_W] = x_q[i];
    assign sprite_y[i*COORD_W +: COORD_W] = y_q[i];
  end
  assign moving      = state_q != IDLE;
  assign move_done   = done_q;
  assign move_reject = rej_q;
endmodule

// File: tb/tb_sprite_grid_mover.sv
// tb_sprite_grid_mover: directed table, corner sequences and random stimulus against a behavioural sprite model
module tb_sprite_grid_mover;
`ifdef SPRITE_STEP_ANIM_EN
  localparam bit ANIM = 1'b1;
`else
  localparam bit ANIM = 1'b0;
`endif
  logic        clk = 1'b0, reset = 1'b0, frame_tick = 1'b0;
  logic        btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
  logic [3:0]  sel = 4'b0;
  logic [39:0] sprite_x, sprite_y;
  logic        moving, move_done, move_reject;
  always #5 clk = ~clk;
  sprite_grid_mover dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
    .sel(sel), .sprite_x(sprite_x), .sprite_y(sprite_y),
    .moving(moving), .move_done(move_done), .move_reject(move_reject)
  );
  int errors = 0, checks = 0;
  int mx[4], my[4];
  int busy, ti, td, tt, cnt;
  bit [3:0] prev_b, edge_d;
  bit e_done, e_rej;
  int done_seen, rej_seen, mov_seen;
  typedef struct {
    bit [3:0] b; bit [3:0] s; bit hold; int nf; int chk; int ex; int ey; int edone; int erej;
  } vec_t;
  vec_t tbl[12];
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic model_reset();
    mx = '{95, 400, 510, 320};
    my = '{85, 400, 85, 200};
    busy = 0; cnt = 0; prev_b = 0; edge_d = 0; e_done = 0; e_rej = 0;
  endtask
  task automatic model_move();
    int sign;
    sign = (td == 1 || td == 3) ? 1 : -1;
    if (td < 2) my[ti] = ANIM ? my[ti] + sign : tt;
    else mx[ti] = ANIM ? mx[ti] + sign : tt;
  endtask
  // busy: 0 idle, 1 waiting for a frame, 2 moving
  task automatic model_step(input bit rst_n, input bit [3:0] b, input bit [3:0] s, input bit ft);
    int d, t;
    if (!rst_n) begin
      model_reset();
      return;
    end
    e_done = 0; e_rej = 0;
    d = edge_d[0] ? 0 : edge_d[1] ? 1 : edge_d[2] ? 2 : edge_d[3] ? 3 : -1;
    if (busy == 0) begin
      if (d >= 0 && (s == 1 || s == 2 || s == 4 || s == 8)) begin
        ti = s[0] ? 0 : s[1] ? 1 : s[2] ? 2 : 3;
        t = (d < 2 ? my[ti] : mx[ti]) + ((d == 1 || d == 3) ? 20 : -20);
        if (t < 10 || t > (d < 2 ? 469 : 629)) e_rej = 1;
        else begin busy = 1; td = d; tt = t; end
      end
    end else if (busy == 1) begin
      if (ft) begin busy = 2; cnt = 1; model_move(); end
    end else begin
      if (!ANIM || cnt == 20) begin e_done = 1; busy = 0; end
      else if (ft) begin model_move(); cnt++; end
    end
    edge_d = b & ~prev_b;
    prev_b = b;
  endtask
  task automatic cyc(input bit rst_n, input bit [3:0] b, input bit [3:0] s, input bit ft);
    logic [39:0] ex, ey;
    reset = rst_n;
    {btn_right, btn_left, btn_down, btn_up} = b;
    sel = s;
    frame_tick = ft;
    model_step(rst_n, b, s, ft);
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      ex[i*10 +: 10] = mx[i][9:0];
      ey[i*10 +: 10] = my[i][9:0];
    end
    check("cycle_model", {sprite_x, sprite_y, moving, move_done, move_reject},
          {ex, ey, busy != 0, e_done, e_rej});
    done_seen += int'(move_done);
    rej_seen  += int'(move_reject);
    mov_seen  += int'(moving);
  endtask
  function automatic int nfe(input int n);
    return (ANIM && n < 25) ? 25 : n;
  endfunction
  task automatic frames(input int n, input bit [3:0] b, input bit [3:0] s);
    for (int k = 0; k < n; k++) begin
      cyc(1, b, s, 1);
      cyc(1, b, s, 0);
      cyc(1, b, s, 0);
    end
  endtask
  initial begin
    bit [3:0] rb, rs;
    logic [9:0] c;
    model_reset();
    tbl[0]  = '{4'b0100, 4'b0001, 0, 1,  0, 75,  85,  1, 0};
    tbl[1]  = '{4'b0001, 4'b0001, 0, 1,  0, 75,  65,  1, 0};
    tbl[2]  = '{4'b0001, 4'b0001, 0, 1,  0, 75,  45,  1, 0};
    tbl[3]  = '{4'b0001, 4'b0001, 0, 1,  0, 75,  25,  1, 0};
    tbl[4]  = '{4'b0001, 4'b0001, 0, 1,  0, 75,  25,  0, 1};
    tbl[5]  = '{4'b1000, 4'b0010, 1, 10, 1, 420, 400, 1, 0};
    tbl[6]  = '{4'b0010, 4'b0011, 0, 1,  0, 75,  25,  0, 0};
    tbl[7]  = '{4'b0010, 4'b0000, 0, 1,  1, 420, 400, 0, 0};
    tbl[8]  = '{4'b0010, 4'b1000, 0, 1,  3, 320, 220, 1, 0};
    tbl[9]  = '{4'b0100, 4'b0100, 0, 1,  2, 490, 85,  1, 0};
    tbl[10] = '{4'b0101, 4'b0100, 0, 1,  2, 490, 65,  1, 0};
    tbl[11] = '{4'b1000, 4'b0001, 0, 1,  0, 95,  25,  1, 0};
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 1);
    check("rst_x", sprite_x, {10'd320, 10'd510, 10'd400, 10'd95});
    check("rst_y", sprite_y, {10'd200, 10'd85, 10'd400, 10'd85});
    check("rst_flags", {moving, move_done, move_reject}, 3'b000);
    for (int i = 0; i < 12; i++) begin
      done_seen = 0; rej_seen = 0; mov_seen = 0;
      cyc(1, tbl[i].b, tbl[i].s, 0);
      repeat (3) cyc(1, tbl[i].hold ? tbl[i].b : 4'b0, tbl[i].s, 0);
      frames(nfe(tbl[i].nf), tbl[i].hold ? tbl[i].b : 4'b0, tbl[i].s);
      repeat (3) cyc(1, 0, tbl[i].s, 0);
      check($sformatf("vec%0d_done", i), done_seen, tbl[i].edone);
      check($sformatf("vec%0d_reject", i), rej_seen, tbl[i].erej);
      check($sformatf("vec%0d_moving", i), mov_seen != 0, tbl[i].edone != 0);
      check($sformatf("vec%0d_x", i), sprite_x[tbl[i].chk*10 +: 10], tbl[i].ex);
      check($sformatf("vec%0d_y", i), sprite_y[tbl[i].chk*10 +: 10], tbl[i].ey);
    end
    // request latency: seen one edge after the button is sampled high
    cyc(1, 4'b1000, 4'b0001, 0);
    check("lat_edge_n", moving, 1'b0);
    cyc(1, 0, 4'b0001, 0);
    check("lat_edge_n1", moving, 1'b1);
    frames(nfe(1), 0, 4'b0001);
    // request and frame_tick together: latched, moved only on the following tick; pending press dropped
    done_seen = 0;
    cyc(1, 4'b0100, 4'b0010, 0);
    cyc(1, 0, 4'b0010, 1);
    check("same_cycle_latch", moving, 1'b1);
    cyc(1, 0, 4'b0010, 0);
    c = sprite_x[19:10];
    check("same_cycle_no_move", c, 10'd420);
    cyc(1, 4'b1000, 4'b0011, 0);
    cyc(1, 0, 4'b0001, 0);
    frames(nfe(1), 0, 4'b0001);
    c = sprite_x[19:10];
    check("pending_drop_x", c, 10'd400);
    check("pending_drop_done", done_seen, 1);
    // reset during a move of sprite 2
    cyc(1, 4'b0100, 4'b0100, 0);
    cyc(1, 0, 4'b0100, 0);
    frames(6, 0, 4'b0100);
    cyc(0, 0, 4'b0100, 1);
    check("midrst_x", sprite_x, {10'd320, 10'd510, 10'd400, 10'd95});
    check("midrst_y", sprite_y, {10'd200, 10'd85, 10'd400, 10'd85});
    check("midrst_moving", moving, 1'b0);
    cyc(1, 0, 4'b0100, 0);
    cyc(1, 4'b0100, 4'b0100, 0);
    cyc(1, 0, 4'b0100, 0);
    frames(nfe(1), 0, 4'b0100);
    c = sprite_x[29:20];
    check("after_rst_move", c, 10'd490);
    rb = 0;
    for (int n = 0; n < 3000; n++) begin
      for (int j = 0; j < 4; j++) if ($urandom % 8 == 0) rb[j] = ~rb[j];
      case ($urandom % 10)
        0, 4: rs = 4'b0001;
        1, 5: rs = 4'b0010;
        2, 6: rs = 4'b0100;
        3, 7: rs = 4'b1000;
        8:    rs = 4'b0110;
        default: rs = 4'b0000;
      endcase
      cyc(($urandom % 400) != 0, rb, rs, ($urandom % 6) == 0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sprite_grid_mover.md
# sprite_grid_mover

Upstream stage of the VGA display path. Turns debounced direction-button levels and the sprite-select switches into one-grid-cell moves of four player sprites, and publishes their centre coordinates to the pixel compositor. Each button press produces exactly one move. Position updates are tied to the frame strobe, so coordinates never change mid-frame.

## Interface
Parameters:
- GRID_STEP, 20: pixels per move.
- X_MIN, 10 / X_MAX, 629: legal range of the sprite centre x coordinate, inclusive.
- Y_MIN, 10 / Y_MAX, 469: legal range of the sprite centre y coordinate, inclusive.

Ports:
- clk  in  1: single clock for the whole block.
- reset  in  1: synchronous, active-low.
- frame_tick  in  1: one-cycle pulse in the clk domain, once per frame (synchronised screenEnd).
- btn_up, btn_down, btn_left, btn_right  in  1 each: debounced button levels.
- sel  in  4: sprite-select switches; must be one-hot to select a sprite.
- sprite_x  out  40: four 10-bit x centres; sprite i occupies bits [10i+9:10i].
- sprite_y  out  40: four 10-bit y centres, same packing.
- moving  out  1: high while a move is pending or in progress.
- move_done  out  1: one-cycle pulse when a move completes.
- move_reject  out  1: one-cycle pulse when a request is dropped because the target is out of bounds.

## Operation
Reset values (reset low at a clk edge):
- Positions: sprite 0 = (95,85), sprite 1 = (400,400), sprite 2 = (510,85), sprite 3 = (320,200).
- moving = 0, move_done = 0, move_reject = 0, state = IDLE.

Edge detection:
- Each button is registered. A request is a rising edge, i.e. a 0→1 transition between consecutive cycles.
- If several edges occur in the same cycle, priority is up > down > left > right; the others are discarded.

State machine:
- IDLE:
  - On a request with sel one-hot, latch the sprite index, direction and target (current ± GRID_STEP on one axis).
  - Target out of [MIN, MAX]: pulse move_reject and stay in IDLE.
  - Target in range: go to PENDING.
  - sel zero or multi-hot: the request is ignored with no pulse.
- PENDING: on frame_tick go to STEP. Further requests are dropped; there is no queue.
- STEP: apply the move (see Configuration). On completion, pulse move_done and return to IDLE. Requests during STEP are dropped.

Rules:
- Changing sel after the latch has no effect on a move in progress.
- Arithmetic is 10-bit unsigned. The bounds check is done in 11 bits, so an underflow below 0 is treated as out of range and never wraps.
- moving = (state != IDLE).

## Timing
- Button rise at edge N: the request is seen at edge N+1. moving rises after edge N+1 (or move_reject pulses for that cycle instead).
- A request and a frame_tick in the same cycle: the request is latched, and the move starts at the next frame_tick.
- Coordinate outputs are registered and change only in the cycle after a frame_tick.
- Reset asserted mid-move: all state returns to its reset values at that edge. A partially slid sprite snaps back to its initial position.

## Configuration
Macro SPRITE_STEP_ANIM_EN:
- Defined: STEP moves the sprite 1 px per frame_tick. A GRID_STEP-bit counter is used. move_done pulses in the cycle after the GRID_STEP-th tick, so the move takes GRID_STEP frames in total.
- Undefined: the full GRID_STEP jump is applied at the PENDING→STEP frame_tick. move_done pulses the next cycle and STEP lasts one cycle. The step counter is not built.

## Structure
- Package sprite_pkg holds:
  - COORD_W = 10 and N_SPRITES = 4;
  - the four initial (x,y) constants;
  - dir_t enum {DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT};
  - state_t enum {IDLE, PENDING, STEP}.
- Sub-module btn_edge_detect: four registered rising-edge detectors plus the priority encoder that outputs a valid bit and a dir_t.

## Test plan
- Reset release, sel=0001, single btn_left pulse, then frame_tick → sprite 0 x goes 95→75 and move_done pulses once. Sprites 1–3 unchanged.
- sel=0001, btn_up pressed and released four times, each followed by frame_tick → y goes 85→65→45→25. The fourth press (target 5) pulses move_reject and y stays 25.
- Holding btn_right high for 10 frames with sel=0010 → exactly one move: sprite 1 x goes 400→420.
- sel=0011, then sel=0000, each with a btn_down press → no moves and no pulses; moving stays 0.
- With SPRITE_STEP_ANIM_EN, sel=1000, btn_down, then 25 frame_ticks → y rises by 1 per tick, 200→220. move_done pulses after the 20th tick. A press during the slide is dropped.
- Reset asserted at the 7th tick of an animated move of sprite 2 → outputs return to (510,85), moving=0, and the next press works normally.
